determ_fxp_to_bits: RTL and testbench

DETERM_FXP_TO_BITS -- requirements
Module: determ_fxp_to_bits

---
 rtl/determ_fxp_to_bits.sv | 99 +++++++++
 tb/tb_determ_fxp_to_bits.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/determ_fxp_to_bits.sv
// Deterministic unary bitstream encoder: a signed fixed-point x in [-1,1) becomes
// an N-bit stream of ones-then-zeros whose +/-1 mean approximates x.
module determ_fxp_to_bits #(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] x,
  output logic                        bit_out,
  output logic                        bit_valid,
  input  logic                        out_ready,
  output logic                        last,
  output logic                        busy,
  output logic                        dbg_state
);

  localparam int FRAC  = BIT_WIDTH - INT_WIDTH;
  localparam int SHIFT = FRAC + 1 - LEN_WIDTH;
  localparam int N     = 2 ** LEN_WIDTH;

  localparam logic signed [BIT_WIDTH:0] C_ONE  = (BIT_WIDTH+1)'(2 ** FRAC);
  localparam logic signed [BIT_WIDTH:0] C_N    = (BIT_WIDTH+1)'(N);
  localparam logic signed [BIT_WIDTH:0] C_ZERO = '0;
  localparam logic [LEN_WIDTH-1:0]      C_LAST = '1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_WIDTH:0]     r_ones, w_ones_nxt;

  logic signed [BIT_WIDTH:0] w_s;
  logic signed [BIT_WIDTH:0] w_sh;
  logic [LEN_WIDTH:0]        w_ones_sat;
  logic                      w_run;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_xfer;

  // Offset x by +1.0 so the ones count is non-negative, then scale to N.
  assign w_s  = (BIT_WIDTH+1)'(x) + C_ONE;
  assign w_sh = w_s >>> SHIFT;

  always_comb begin
    w_ones_sat = '0;
    if (w_s <= C_ZERO)
      w_ones_sat = '0;
    else if (w_sh >= C_N)
      w_ones_sat = (LEN_WIDTH+1)'(N);
    else
      w_ones_sat = (LEN_WIDTH+1)'(w_sh);
  end

  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == C_LAST);
  assign w_xfer   = w_run && out_ready;
  // Ready while idle, or on the final transfer so the next stream follows with no gap.
  assign in_ready = !RST && (!w_run || (w_last && out_ready));
  assign w_accept = in_valid && in_ready;

  assign bit_valid = w_run;
  assign bit_out   = w_run && ({1'b0, r_cnt} < r_ones);
  assign last      = w_last;
  assign busy      = w_run;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ones_nxt  = r_ones;
    if (w_accept) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_ones_nxt  = w_ones_sat;
    end else if (w_xfer) begin
      if (w_last)
        w_state_nxt = S_IDLE;
      else
        w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ones  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ones  <= w_ones_nxt;
    end
  end

endmodule

// File: tb/tb_determ_fxp_to_bits.sv
// Bench for determ_fxp_to_bits: two instances (INT_WIDTH=1 and INT_WIDTH=2, N=16)
// driven with shared inputs and checked against hand-computed ones counts.
module tb_determ_fxp_to_bits;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] x;
  logic        out_ready;

  logic a_in_ready, a_bit_out, a_bit_valid, a_last, a_busy, a_dbg;
  logic b_in_ready, b_bit_out, b_bit_valid, b_last, b_busy, b_dbg;

  int n_cmp;
  int n_bad;

  determ_fxp_to_bits #(.BIT_WIDTH(16), .INT_WIDTH(1), .LEN_WIDTH(4)) dut_a (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(a_in_ready), .x(x),
    .bit_out(a_bit_out), .bit_valid(a_bit_valid), .out_ready(out_ready),
    .last(a_last), .busy(a_busy), .dbg_state(a_dbg)
  );

  determ_fxp_to_bits #(.BIT_WIDTH(16), .INT_WIDTH(2), .LEN_WIDTH(4)) dut_b (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(b_in_ready), .x(x),
    .bit_out(b_bit_out), .bit_valid(b_bit_valid), .out_ready(out_ready),
    .last(b_last), .busy(b_busy), .dbg_state(b_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    int          exp_a;
    int          exp_b;
    bit          stall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " a_bit_valid"}, int'(a_bit_valid), 0);
    chk({tag, " a_busy"},      int'(a_busy), 0);
    chk({tag, " a_last"},      int'(a_last), 0);
    chk({tag, " a_bit_out"},   int'(a_bit_out), 0);
    chk({tag, " b_bit_valid"}, int'(b_bit_valid), 0);
    chk({tag, " b_busy"},      int'(b_busy), 0);
  endtask

  // Starts at posedge+1 with the first bit presented; returns at posedge+1 after nbits transfers.
  task automatic consume_stream(input int exp_a, input int exp_b, input bit stall,
                                input int nbits, input string tag);
    int taken;
    int cyc;
    taken = 0;
    cyc   = 0;
    while (taken < nbits && cyc < 64) begin
      out_ready = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk({tag, " a_bit_valid"}, int'(a_bit_valid), 1);
      chk({tag, " a_bit_out"},   int'(a_bit_out), int'(taken < exp_a));
      chk({tag, " a_last"},      int'(a_last), int'(taken == 15));
      chk({tag, " a_busy"},      int'(a_busy), 1);
      chk({tag, " a_in_ready"},  int'(a_in_ready), int'(taken == 15 && out_ready));
      chk({tag, " b_bit_valid"}, int'(b_bit_valid), 1);
      chk({tag, " b_bit_out"},   int'(b_bit_out), int'(taken < exp_b));
      chk({tag, " b_last"},      int'(b_last), int'(taken == 15));
      @(posedge clk);
      #1;
      if (out_ready) taken++;
      cyc++;
    end
    if (taken < nbits) chk({tag, " timeout transfers"}, taken, nbits);
  endtask

  task automatic start_stream(input logic [15:0] xv, input string tag);
    in_valid = 1'b1;
    x        = xv;
    #1;
    chk({tag, " accept a_in_ready"}, int'(a_in_ready), 1);
    chk({tag, " accept b_in_ready"}, int'(b_in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = 16'($urandom);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = 16'h0000;
    out_ready = 1'b1;

    vecs[0]  = '{16'h0000,  8,  8, 1'b0};
    vecs[1]  = '{16'h4000, 12, 16, 1'b0};
    vecs[2]  = '{16'h8000,  0,  0, 1'b0};
    vecs[3]  = '{16'h7FFF, 15, 16, 1'b0};
    vecs[4]  = '{16'hC000,  4,  0, 1'b0};
    vecs[5]  = '{16'h0001,  8,  8, 1'b0};
    vecs[6]  = '{16'h0FFF,  8,  9, 1'b0};
    vecs[7]  = '{16'h1000,  9, 10, 1'b0};
    vecs[8]  = '{16'h6000, 14, 16, 1'b0};
    vecs[9]  = '{16'hA000,  2,  0, 1'b0};
    vecs[10] = '{16'hE000,  6,  4, 1'b0};
    vecs[11] = '{16'h4000, 12, 16, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset a_in_ready", int'(a_in_ready), 0);
    chk("reset b_in_ready", int'(b_in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post-reset a_in_ready", int'(a_in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      start_stream(vecs[i].x, $sformatf("vec%0d", i));
      consume_stream(vecs[i].exp_a, vecs[i].exp_b, vecs[i].stall, 16, $sformatf("vec%0d", i));
      check_idle($sformatf("vec%0d end", i));
      chk($sformatf("vec%0d end a_in_ready", i), int'(a_in_ready), 1);
    end

    // Back-to-back: in_valid held, second accept coincides with first stream's last bit.
    in_valid = 1'b1;
    x        = 16'h0000;
    @(posedge clk);
    #1;
    x = 16'h4000;
    consume_stream(8, 8, 1'b0, 16, "b2b s1");
    in_valid = 1'b0;
    x        = 16'($urandom);
    consume_stream(12, 16, 1'b0, 16, "b2b s2");
    check_idle("b2b end");

    // Reset mid-stream while the 5th bit is presented.
    start_stream(16'h0000, "rst");
    consume_stream(8, 8, 1'b0, 4, "rst pre");
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst in_ready low", int'(a_in_ready), 0);
    @(posedge clk);
    #1;
    check_idle("rst abort");
    rst = 1'b0;
    #1;
    chk("rst release a_in_ready", int'(a_in_ready), 1);
    chk("rst release b_in_ready", int'(b_in_ready), 1);
    start_stream(16'h0000, "rst new");
    consume_stream(8, 8, 1'b0, 16, "rst new");
    check_idle("rst new end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
